tinker_sequencer: RTL and testbench

TINKER_SEQUENCER -- requirements
Module: tinker_sequencer

---
 rtl/tinker_sequencer.sv | 164 ++++++++++++++++
 tb/tb_tinker_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_sequencer.sv
// rtl/tinker_sequencer.sv - Fetch/decode/execute/writeback instruction sequencer FSM
//
// Purpose: steps one instruction at a time through FETCH, DECODE, EXEC, an
// optional WAIT for multi-cycle ALU/FPU ops, and WB.  It stops in HALT on
// opcode 0x0F, on an illegal opcode, or on an ALU timeout.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   run        in   allows the next instruction fetch to start
//   imem_req   out  fetch request, high only in FETCH
//   imem_addr  out  fetch address (always the current pc)
//   imem_ack   in   fetch data valid; sampled only in FETCH
//   imem_rdata in   fetched instruction word
//   instr      out  latched instruction word
//   alu_start  out  one-cycle start pulse for multi-cycle ops
//   alu_done   in   multi-cycle result valid; sampled only in WAIT
//   rf_we      out  one-cycle register-file write strobe
//   pc         out  program counter
//   halted     out  sequencer stopped (sticky until reset)
//   err        out  stop caused by an illegal opcode or ALU timeout
//   state      out  FSM state encoding
module tinker_sequencer #(
   parameter logic [63:0] PC_RESET    = 64'h2000,
   parameter int unsigned ALU_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        alu_start,
   input  logic        alu_done,
   output logic        rf_we,
   output logic [63:0] pc,
   output logic        halted,
   output logic        err,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WAIT   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [16:0] TIMEOUT_L = ALU_TIMEOUT[16:0];

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        err_q, err_d;
   logic [4:0]  opcode;
   logic [16:0] wcnt_inc;

   function automatic logic op_legal(input logic [4:0] op);
      return (op <= 5'h07) || (op == 5'h11) || (op == 5'h12) ||
             ((op >= 5'h14) && (op <= 5'h1D));
   endfunction

   function automatic logic op_multi(input logic [4:0] op);
      return (op == 5'h16) || (op == 5'h17) || (op == 5'h1C) || (op == 5'h1D);
   endfunction

   assign opcode   = instr_q[31:27];
   // One bit wider than the counter so a timeout of 65536 still compares correctly.
   assign wcnt_inc = {1'b0, wcnt_q} + 17'd1;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      imem_req  = 1'b0;
      alu_start = 1'b0;
      rf_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode == 5'h0F) begin
               state_d = S_HALT;
            end else if (op_legal(opcode)) begin
               state_d = S_EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end
         end
         S_EXEC: begin
            wcnt_d = '0;
            if (op_multi(opcode)) begin
               alu_start = 1'b1;
               state_d   = S_WAIT;
            end else begin
               state_d = S_WB;
            end
         end
         S_WAIT: begin
            // alu_done is tested first so it wins over a timeout in the same cycle.
            if (alu_done) begin
               state_d = S_WB;
            end else if (wcnt_inc >= TIMEOUT_L) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               wcnt_d = wcnt_inc[15:0];
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_d    = pc_q + 64'd4;
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign halted    = (state_q == S_HALT);
   assign err       = err_q;
   assign state     = state_q;

endmodule

// File: tb/tb_tinker_sequencer.sv
// tb/tb_tinker_sequencer.sv - Scoreboard bench for tinker_sequencer
module tb_tinker_sequencer;

   localparam logic [63:0] PCR  = 64'h2000;
   localparam logic [63:0] WPCR = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam int          TMO  = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        imem_req, alu_start, rf_we, halted, err;
   logic [63:0] imem_addr, pc;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic        alu_done = 1'b0;
   logic [2:0]  state;

   logic        w_req, w_alu_start, w_rf_we, w_halted, w_err;
   logic [63:0] w_addr, w_pc;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = 32'hC000_0000;
   logic [31:0] w_instr;
   logic        w_done = 1'b0;
   logic [2:0]  w_state;

   tinker_sequencer #(.PC_RESET(PCR), .ALU_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .alu_start(alu_start), .alu_done(alu_done), .rf_we(rf_we),
      .pc(pc), .halted(halted), .err(err), .state(state));

   tinker_sequencer #(.PC_RESET(WPCR), .ALU_TIMEOUT(TMO)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .run(run),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
      .instr(w_instr), .alu_start(w_alu_start), .alu_done(w_done), .rf_we(w_rf_we),
      .pc(w_pc), .halted(w_halted), .err(w_err), .state(w_state));

   always #5 clk = ~clk;

   typedef struct {
      bit          halt;
      logic [63:0] pc;
      logic [31:0] word;
      bit          err;
      int          waits;
      int          starts;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog_word[$];
   int          prog_dly[$];
   int          alu_dq[$];
   logic [4:0]  legal_ops[$];

   int          checks = 0;
   int          errors = 0;
   int          rst_cnt = 0;
   int          fix_dly = -1;
   bit          exp_is_halt;
   bit          last_err;
   logic [63:0] last_pc;

   function automatic bit is_legal(input logic [4:0] op);
      return op inside {[5'h00:5'h07], 5'h11, 5'h12, [5'h14:5'h1D]};
   endfunction

   function automatic bit is_multi(input logic [4:0] op);
      return op inside {5'h16, 5'h17, 5'h1C, 5'h1D};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge reset_n) rst_cnt++;

   // Instruction memory: acks after fetch delay, random ack noise while not fetching.
   initial begin
      int  fdly;
      bit  acked;
      fdly  = 0;
      acked = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            imem_ack = 1'b0;
            acked    = 0;
            fdly     = (fix_dly >= 0) ? fix_dly : int'($urandom % 4);
         end else begin
            if (acked) begin
               if (prog_word.size() != 0) begin
                  if (is_multi(prog_word[0][31:27])) alu_dq.push_back(prog_dly[0]);
                  void'(prog_word.pop_front());
                  void'(prog_dly.pop_front());
               end
               acked = 0;
               fdly  = (fix_dly >= 0) ? fix_dly : int'($urandom % 4);
            end
            if (imem_req) begin
               imem_ack = 1'b0;
               if (prog_word.size() != 0) begin
                  if (fdly == 0) begin
                     imem_ack   = 1'b1;
                     imem_rdata = prog_word[0];
                     acked      = 1;
                  end else begin
                     fdly--;
                  end
               end
            end else begin
               imem_ack   = ($urandom % 2) == 1;
               imem_rdata = $urandom;
            end
         end
      end
   end

   // ALU: done pulse d cycles after alu_start (d=0 means never); noise when idle.
   initial begin
      int rem;
      bit pend;
      rem  = 0;
      pend = 0;
      forever begin
         @(negedge clk);
         if (alu_start) begin
            rem      = (alu_dq.size() != 0) ? alu_dq.pop_front() : 0;
            if (rem == 0) rem = -1;
            pend     = 1;
            alu_done = 1'b0;
         end else if (pend) begin
            alu_done = 1'b0;
            if (rem > 0) begin
               rem--;
               if (rem == 0) begin
                  alu_done = 1'b1;
                  pend     = 0;
               end
            end
         end else begin
            alu_done = ($urandom % 4) == 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         w_ack = w_req;
      end
   end

   // Monitor: pops the scoreboard on every rf_we pulse and on entry to HALT.
   initial begin
      int          last_rc, wcount, scount;
      bit          was_h, was_req;
      logic [63:0] prev_pc;
      logic [2:0]  prev_state;
      exp_t        e;
      last_rc = 0; wcount = 0; scount = 0; was_h = 0; was_req = 0;
      prev_pc = PCR; prev_state = 3'd0;
      forever begin
         @(negedge clk);
         if (!reset_n || rst_cnt != last_rc) begin
            last_rc = rst_cnt; wcount = 0; scount = 0; was_h = 0; was_req = 0;
            prev_pc = pc; prev_state = state;
            continue;
         end
         if (state == 3'd4) wcount++;
         if (alu_start) scount++;
         if (pc !== prev_pc) chk("pc_changed_outside_wb", 64'(prev_state), 64'(3'd5));
         if (imem_req && !was_req && sb.size() != 0) chk("imem_addr", imem_addr, sb[0].pc);
         if (rf_we || (halted && !was_h)) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_event: rf_we=%0b halted=%0b with empty scoreboard", rf_we, halted);
            end else begin
               e = sb.pop_front();
               chk("event_kind_halt", 64'(halted), 64'(e.halt));
               chk("event_pc", pc, e.pc);
               chk("wait_cycles", 64'(wcount), 64'(e.waits));
               chk("alu_start_pulses", 64'(scount), 64'(e.starts));
               if (rf_we) chk("instr", 64'(instr), 64'(e.word));
               else       chk("err", 64'(err), 64'(e.err));
            end
            wcount = 0;
            scount = 0;
         end
         was_h      = halted;
         was_req    = imem_req;
         prev_pc    = pc;
         prev_state = state;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      run     = 1'b0;
      reset_n = 1'b0;
      sb.delete(); prog_word.delete(); prog_dly.delete(); alu_dq.delete();
      #1;
      chk("rst_ctrl", 64'({state, imem_req, alu_start, rf_we, halted, err}), 64'(0));
      chk("rst_pc", pc, PCR);
      chk("rst_instr", 64'(instr), 64'(0));
      chk("rst_wrap_pc", w_pc, WPCR);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic add_instr(input logic [31:0] w, input int d);
      prog_word.push_back(w);
      prog_dly.push_back(d);
   endtask

   task automatic build_expect();
      logic [63:0] p;
      logic [4:0]  op;
      exp_t        e;
      p = PCR;
      exp_is_halt = 0;
      for (int i = 0; i < prog_word.size(); i++) begin
         op = prog_word[i][31:27];
         e.pc = p; e.word = prog_word[i]; e.halt = 0; e.err = 0; e.waits = 0; e.starts = 0;
         if (op == 5'h0F) begin
            e.halt = 1;
         end else if (!is_legal(op)) begin
            e.halt = 1; e.err = 1;
         end else if (is_multi(op)) begin
            e.starts = 1;
            if (prog_dly[i] == 0 || prog_dly[i] > TMO) begin
               e.halt = 1; e.err = 1; e.waits = TMO;
            end else begin
               e.waits = prog_dly[i];
            end
         end
         sb.push_back(e);
         if (e.halt) begin
            exp_is_halt = 1; last_pc = p; last_err = e.err;
            break;
         end
         p += 64'd4;
      end
   endtask

   task automatic run_prog(input int budget, input bit rnd_run);
      int n;
      n = 0;
      build_expect();
      while (sb.size() != 0 && n < budget) begin
         run = rnd_run ? (($urandom % 4) != 0) : 1'b1;
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d expectations left, got none within %0d cycles", sb.size(), budget);
      end
      if (exp_is_halt) begin
         run = 1'b1;
         repeat (6) begin
            @(negedge clk); #1;
            chk("halt_outputs", 64'({halted, err, imem_req, alu_start, rf_we, state}),
                64'({1'b1, last_err, 1'b0, 1'b0, 1'b0, 3'd6}));
            chk("halt_pc", pc, last_pc);
         end
      end
   endtask

   initial begin
      int n, w, r, len;
      logic [4:0] op;
      for (int i = 0; i < 32; i++) if (is_legal(5'(i))) legal_ops.push_back(5'(i));

      // Single add, fetch acked two cycles after the request.
      fix_dly = 2;
      do_reset();
      add_instr(32'hC000_0000, 0);
      run_prog(100, 0);
      @(negedge clk); #1;
      chk("after_wb_state", 64'(state), 64'(3'd1));
      chk("after_wb_addr", imem_addr, PCR + 64'd4);
      fix_dly = -1;

      // Directed multi-cycle, timeout boundary and halt cases.
      do_reset(); add_instr(32'hE000_0000 | 32'($urandom % 1024), 5);  run_prog(200, 1);
      do_reset(); add_instr(32'hE800_0000, 0);                         run_prog(300, 1);
      do_reset(); add_instr(32'hE000_0000, TMO);                        run_prog(300, 1);
      do_reset(); add_instr(32'hB800_0000, TMO + 1);                    run_prog(300, 1);
      do_reset(); add_instr(32'h7800_0000, 0);                          run_prog(100, 1);
      do_reset(); add_instr(32'h4000_0000, 0);                          run_prog(100, 1);

      // Wrap of pc from PC_RESET = 2^64-4 on the second instance.
      do_reset();
      run = 1'b1;
      n = 0;
      while (!w_rf_we && n < 50) begin @(negedge clk); #1; n++; end
      chk("wrap_wb_seen", 64'(w_rf_we), 64'(1));
      chk("wrap_pc_before", w_pc, WPCR);
      @(negedge clk); #1;
      chk("wrap_pc_after", w_pc, 64'h0);

      // Reset pulse during WAIT: abandon instruction, ignore the late alu_done.
      do_reset();
      add_instr(32'hE000_0000, 20);
      build_expect();
      run = 1'b1;
      n = 0; w = 0;
      while (w < 5 && n < 100) begin
         @(negedge clk); #1;
         if (state == 3'd4) w++;
         n++;
      end
      chk("reached_wait", 64'(w), 64'(5));
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_ctrl", 64'({state, imem_req, alu_start, rf_we, halted, err}), 64'(0));
      chk("async_rst_pc", pc, PCR);
      chk("async_rst_addr", imem_addr, PCR);
      chk("async_rst_instr", 64'(instr), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      run     = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("post_rst_state", 64'(state), 64'(3'd0));
      chk("post_rst_pc", pc, PCR);

      // Random programs with random run gaps, fetch delays and ALU latencies.
      for (int t = 0; t < 14; t++) begin
         do_reset();
         len = 1 + int'($urandom % 6);
         for (int k = 0; k < len; k++) begin
            r = int'($urandom % 10);
            if (r < 7)       op = legal_ops[$urandom % legal_ops.size()];
            else if (r == 7) op = 5'h0F;
            else             op = 5'($urandom % 32);
            r = int'($urandom % 10);
            add_instr({op, 27'($urandom)},
                      (r < 7) ? 1 + int'($urandom % 12) : (r == 7) ? 0 : (r == 8) ? TMO : TMO + 1);
         end
         run_prog(2000, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
